// File: rtl/spi_tx_engine.sv
// spi_tx_engine: SPI master transmitter that drains a registered-read FIFO onto sclk/mosi/cs_n
// Ports: clk, rst (async, active-high); full/empty/read_data/read_en face the FIFO read side;
//        sclk/mosi/cs_n drive the SPI pins; done pulses once per word; busy is high outside IDLE.
module spi_tx_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV = 2,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit BURST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  full,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_en,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs_n,
  output logic                  done,
  output logic                  busy
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int EW = $clog2(2 * DATA_WIDTH + 1);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SETUP, SHIFT, HOLD, COMPLETE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [EW-1:0] edge_cnt_q, edge_cnt_d;
  logic [DATA_WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic read_en_q, read_en_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic cs_n_q, cs_n_d, done_q, done_d, busy_q, busy_d;
  logic avail, timed, tick, lead, drive;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] x);
    return LSB_FIRST ? x[0] : x[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] x);
    return LSB_FIRST ? x >> 1 : x << 1;
  endfunction

  assign avail = full || !empty;
  assign timed = state_q == SETUP || state_q == SHIFT || state_q == HOLD;
  assign tick = timed && div_cnt_q == CW'(DIV - 1);
  // a leading edge moves sclk away from its idle level
  assign lead = sclk_q == CPOL;
  // CPHA=1 drives on every leading edge; CPHA=0 already drove bit one in LOAD, so it
  // drives on each trailing edge except the final one
  assign drive = state_q == SHIFT && tick && (CPHA ? lead : (!lead && edge_cnt_q != EW'(1)));

  always_comb begin
    state_d = state_q;
    div_cnt_d = (tick || !timed) ? '0 : div_cnt_q + 1'b1;
    edge_cnt_d = edge_cnt_q;
    shift_reg_d = shift_reg_q;
    sclk_d = CPOL;
    mosi_d = mosi_q;
    case (state_q)
      IDLE: state_d = avail ? FETCH : IDLE;
      FETCH: state_d = LOAD;
      LOAD: begin
        state_d = SETUP;
        shift_reg_d = CPHA ? read_data : advance(read_data);
        mosi_d = CPHA ? 1'b0 : first_bit(read_data);
      end
      SETUP: begin
        state_d = tick ? SHIFT : SETUP;
        edge_cnt_d = tick ? EW'(2 * DATA_WIDTH) : edge_cnt_q;
      end
      SHIFT: begin
        sclk_d = tick ? !sclk_q : sclk_q;
        edge_cnt_d = tick ? edge_cnt_q - 1'b1 : edge_cnt_q;
        state_d = (tick && edge_cnt_q == EW'(1)) ? HOLD : SHIFT;
      end
      HOLD: state_d = tick ? COMPLETE : HOLD;
      COMPLETE: state_d = (BURST && avail) ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
    if (drive) begin
      mosi_d = first_bit(shift_reg_q);
      shift_reg_d = advance(shift_reg_q);
    end
    read_en_d = state_d == FETCH;
    done_d = state_d == COMPLETE;
    busy_d = state_d != IDLE;
    // cs_n only moves on SETUP/IDLE entry, so a burst keeps it low through FETCH/LOAD
    cs_n_d = state_d == SETUP ? 1'b0 : state_d == IDLE ? 1'b1 : cs_n_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_cnt_q <= '0;
      edge_cnt_q <= '0;
      shift_reg_q <= '0;
      read_en_q <= 1'b0;
      sclk_q <= CPOL;
      mosi_q <= 1'b0;
      cs_n_q <= 1'b1;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_cnt_q <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      shift_reg_q <= shift_reg_d;
      read_en_q <= read_en_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      cs_n_q <= cs_n_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign read_en = read_en_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign cs_n = cs_n_q;
  assign done = done_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_spi_tx_engine.sv
// tb_spi_tx_engine: randomized self-checking bench for spi_tx_engine across three configurations
module tb_spi_tx_engine;
  localparam int N = 3;
  localparam int DIVS [N] = '{2, 2, 1};
  localparam bit [N-1:0] POL = 3'b010;
  localparam bit [N-1:0] PHA = 3'b110;
  localparam bit [N-1:0] LSB = 3'b010;
  localparam bit [N-1:0] BST = 3'b010;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] full = '0;
  logic [N-1:0] empty = '1;
  logic [7:0] rd [N];
  wire [N-1:0] read_en, sclk, mosi, cs_n, done, busy;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    spi_tx_engine #(
      .DATA_WIDTH(8), .DIV(DIVS[g]), .CPOL(POL[g]), .CPHA(PHA[g]),
      .LSB_FIRST(LSB[g]), .BURST(BST[g])
    ) u_dut (
      .clk(clk), .rst(rst), .full(full[g]), .empty(empty[g]), .read_data(rd[g]),
      .read_en(read_en[g]), .sclk(sclk[g]), .mosi(mosi[g]), .cs_n(cs_n[g]),
      .done(done[g]), .busy(busy[g])
    );
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int tog [N], nb [N], rds [N], dns [N], rises [N], falls [N], viol [N], bad_chg [N];
  int last_done [N], first_tog [N], last_tog [N], first_rd [N], first_fall [N];
  logic [7:0] capw [N];
  logic [N-1:0] p_sclk, p_mosi, p_cs, p_done, p_rd;
  logic [7:0] fq [N][$];
  logic [7:0] got [N][$];
  int gnb [N][$], gtog [N][$], gdc [N][$], gaps [N][$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic clear();
    for (int k = 0; k < N; k++) begin
      tog[k] = 0; nb[k] = 0; rds[k] = 0; dns[k] = 0; rises[k] = 0; falls[k] = 0;
      viol[k] = 0; bad_chg[k] = 0; last_done[k] = -1; first_tog[k] = -1;
      last_tog[k] = -1; first_rd[k] = -1; first_fall[k] = -1; capw[k] = '0;
      got[k].delete(); gnb[k].delete(); gtog[k].delete(); gdc[k].delete(); gaps[k].delete();
    end
    p_sclk = sclk; p_mosi = mosi; p_cs = cs_n; p_done = done; p_rd = read_en;
  endtask

  // one clock: observe every instance at the falling edge and serve FIFO pops
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (sclk[k] !== p_sclk[k]) begin
        if (tog[k] == 0) first_tog[k] = cyc;
        last_tog[k] = cyc;
        tog[k]++;
        if (sclk[k] === (POL[k] == PHA[k])) begin
          if (mosi[k] !== p_mosi[k]) bad_chg[k]++;
          if (nb[k] < 8) capw[k][LSB[k] ? nb[k] : 7 - nb[k]] = mosi[k];
          nb[k]++;
        end
      end
      if (cs_n[k] && !p_cs[k]) rises[k]++;
      if (!cs_n[k] && p_cs[k]) begin
        falls[k]++;
        if (first_fall[k] < 0) first_fall[k] = cyc;
      end
      if ((done[k] && (p_done[k] || read_en[k])) || (read_en[k] && p_rd[k])) viol[k]++;
      if (done[k]) begin
        dns[k]++;
        last_done[k] = cyc;
        got[k].push_back(capw[k]); gnb[k].push_back(nb[k]); gtog[k].push_back(tog[k]);
        gdc[k].push_back(cyc);
        nb[k] = 0; tog[k] = 0; capw[k] = '0;
      end
      if (read_en[k]) begin
        rds[k]++;
        if (first_rd[k] < 0) first_rd[k] = cyc;
        if (last_done[k] >= 0) gaps[k].push_back(cyc - last_done[k]);
        rd[k] = fq[k].size() > 0 ? fq[k].pop_front() : 8'h00;
      end
      p_sclk[k] = sclk[k]; p_mosi[k] = mosi[k]; p_cs[k] = cs_n[k];
      p_done[k] = done[k]; p_rd[k] = read_en[k];
      empty[k] = fq[k].size() == 0;
      full[k] = fq[k].size() >= 4;
    end
  endtask

  task automatic chk_reset();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst_sclk%0d", k), sclk[k], POL[k]);
      chk($sformatf("rst_cs_n%0d", k), cs_n[k], 1);
      chk($sformatf("rst_mosi%0d", k), mosi[k], 0);
      chk($sformatf("rst_read_en%0d", k), read_en[k], 0);
      chk($sformatf("rst_done%0d", k), done[k], 0);
      chk($sformatf("rst_busy%0d", k), busy[k], 0);
    end
  endtask

  // queue n words on instance k (random or w0 + 0x11*i) and check them against the model
  task automatic run(input int k, input int n, input logic [7:0] w0, input bit rnd);
    int t0, lat, budget;
    logic [7:0] w;
    logic [7:0] ex [$];
    clear();
    for (int i = 0; i < n; i++) begin
      w = rnd ? 8'($urandom) : w0 + 8'(17 * i);
      ex.push_back(w);
      fq[k].push_back(w);
    end
    empty[k] = 1'b0;
    full[k] = fq[k].size() >= 4;
    t0 = cyc;
    lat = 2 + DIVS[k] + 16 * DIVS[k] + DIVS[k] + 1;
    budget = 100 * n + 100;
    while (dns[k] < n && budget > 0) begin
      step();
      budget--;
    end
    chk($sformatf("busy_at_done%0d", k), busy[k], 1);
    for (int i = 0; i < n && i < got[k].size(); i++) begin
      chk($sformatf("word%0d_%0d", k, i), got[k][i], ex[i]);
      chk($sformatf("bits%0d_%0d", k, i), gnb[k][i], 8);
      chk($sformatf("toggles%0d_%0d", k, i), gtog[k][i], 16);
      chk($sformatf("latency%0d_%0d", k, i), gdc[k][i] - (i == 0 ? t0 : gdc[k][i-1]),
          i == 0 ? lat : (BST[k] ? lat : lat + 1));
    end
    chk($sformatf("gap_count%0d", k), gaps[k].size(), n - 1);
    for (int i = 0; i < gaps[k].size(); i++)
      chk($sformatf("gap%0d_%0d", k, i), gaps[k][i], BST[k] ? 1 : 2);
    chk($sformatf("first_read_en%0d", k), first_rd[k] - t0, 1);
    chk($sformatf("cs_fall_cycle%0d", k), first_fall[k] - t0, 3);
    if (n == 1) begin
      chk($sformatf("first_toggle%0d", k), first_tog[k] - t0, 3 + 2 * DIVS[k]);
      chk($sformatf("last_toggle%0d", k), last_tog[k] - t0, 3 + 17 * DIVS[k]);
    end
    repeat (20) step();
    chk($sformatf("dones%0d", k), dns[k], n);
    chk($sformatf("reads%0d", k), rds[k], n);
    chk($sformatf("cs_falls%0d", k), falls[k], BST[k] ? 1 : n);
    chk($sformatf("cs_rises%0d", k), rises[k], BST[k] ? 1 : n);
    chk($sformatf("pulse_rules%0d", k), viol[k], 0);
    chk($sformatf("mosi_at_sample%0d", k), bad_chg[k], 0);
    chk($sformatf("idle_busy%0d", k), busy[k], 0);
    chk($sformatf("idle_cs_n%0d", k), cs_n[k], 1);
    chk($sformatf("idle_sclk%0d", k), sclk[k], POL[k]);
  endtask

  initial begin
    int b;
    for (int k = 0; k < N; k++) rd[k] = 8'h00;
    #1 rst = 1'b1;
    #1 chk_reset();
    repeat (3) step();
    rst = 1'b0;
    run(0, 1, 8'hA5, 1'b0);
    run(0, 3, 8'h00, 1'b1);
    run(1, 1, 8'h01, 1'b0);
    run(1, 3, 8'h11, 1'b0);
    run(1, 5, 8'h00, 1'b1);
    run(2, 1, 8'h00, 1'b1);
    run(2, 2, 8'h00, 1'b1);
    clear();
    fq[0].push_back(8'($urandom));
    empty[0] = 1'b0;
    b = 200;
    while (tog[0] < 4 && b > 0) begin
      step();
      b--;
    end
    chk("reach_edge5", tog[0], 4);
    chk("mid_shift_busy", busy[0], 1);
    rst = 1'b1;
    #1 chk_reset();
    step();
    step();
    rst = 1'b0;
    clear();
    repeat (50) step();
    chk("post_rst_reads", rds[0] + rds[1] + rds[2], 0);
    chk("post_rst_dones", dns[0] + dns[1] + dns[2], 0);
    chk("post_rst_busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
